// File: rtl/mem_stage_param.sv
// mem_stage_param: parametrised MEM pipeline stage.
// Holds a byte-addressed little-endian data memory and the MEM/WB register.
// Supports sized, sign/zero-extended loads and stores, an optional
// multi-cycle access latency with a stall back to upstream, and detection
// of misaligned or illegal accesses, which are flagged to WB.
module mem_stage_param #(
   parameter int XLEN        = 64,
   parameter int DEPTH_BYTES = 1024,
   parameter int MEM_LATENCY = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      ex_mem_rd,
   input  logic            ex_mem_Memwrite,
   input  logic            ex_mem_Memread,
   input  logic            ex_mem_MemtoReg,
   input  logic            ex_mem_Regwrite,
   input  logic [2:0]      ex_mem_funct3,
   input  logic [XLEN-1:0] ex_mem_alu_result,
   input  logic [XLEN-1:0] ex_mem_rs2,
   output logic            mem_stall,
   output logic [4:0]      mem_wb_rd,
   output logic            mem_wb_MemtoReg,
   output logic            mem_wb_RegWrite,
   output logic [XLEN-1:0] mem_wb_alu_result,
   output logic [XLEN-1:0] mem_wb_mem_data,
   output logic            mem_wb_exc
);

   localparam int         AW       = $clog2(DEPTH_BYTES);
   localparam bit         IS_RV32  = (XLEN == 32);
   localparam logic [3:0] CNT_INIT = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t       r_state;
   logic [3:0]   r_cnt;
   logic [7:0]   r_mem [DEPTH_BYTES];

   logic [AW-1:0] w_addr;
   logic          w_is_mem;
   logic          w_misaligned;
   logic          w_bad_f3;
   logic          w_illegal;
   logic          w_valid;
   logic          w_complete;
   logic [3:0]    w_nbytes;
   logic [63:0]   w_raw;
   logic [63:0]   w_load_ext;
   logic [63:0]   w_st_data;
   logic          w_unused;

   // Upper address bits are ignored so accesses wrap modulo the memory size.
   assign w_addr    = ex_mem_alu_result[AW-1:0];
   assign w_unused  = ^ex_mem_alu_result[XLEN-1:AW];
   assign w_st_data = 64'(ex_mem_rs2);
   assign w_nbytes  = 4'd1 << ex_mem_funct3[1:0];

   // Alignment requirement per access size.
   always_comb begin
      // NOTE: default every always_comb output first so no path infers a latch.
      w_misaligned = 1'b0;
      case (ex_mem_funct3[1:0])
         2'b01:   w_misaligned = w_addr[0];
         2'b10:   w_misaligned = |w_addr[1:0];
         2'b11:   w_misaligned = |w_addr[2:0];
         default: w_misaligned = 1'b0;
      endcase
   end

   assign w_bad_f3  = (ex_mem_funct3 == 3'b111) ||
                      (IS_RV32 && (ex_mem_funct3 == 3'b011 || ex_mem_funct3 == 3'b110));
   assign w_is_mem  = ex_mem_Memread | ex_mem_Memwrite;
   assign w_illegal = w_is_mem &&
                      ((ex_mem_Memread && ex_mem_Memwrite) || w_misaligned || w_bad_f3);
   assign w_valid   = w_is_mem && !w_illegal;

   // The access completes either straight from IDLE (no latency) or on the
   // last WAIT cycle; this is the only point at which inputs are consumed.
   assign w_complete = w_valid &&
                       (((MEM_LATENCY == 0) && (r_state == S_IDLE)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd0)));

   assign mem_stall = ((r_state == S_IDLE) && w_valid && (MEM_LATENCY > 0)) ||
                      ((r_state == S_WAIT) && (r_cnt != 4'd0));

   // Gather eight consecutive bytes starting at the access address.
   always_comb begin
      w_raw = '0;
      for (int i = 0; i < 8; i++) begin
         w_raw[8*i +: 8] = r_mem[AW'(w_addr + AW'(i))];
      end
   end

   // Size-select and sign/zero-extend the load data.
   always_comb begin
      w_load_ext = '0;
      case (ex_mem_funct3)
         3'b000:  w_load_ext = {{56{w_raw[7]}},  w_raw[7:0]};
         3'b001:  w_load_ext = {{48{w_raw[15]}}, w_raw[15:0]};
         3'b010:  w_load_ext = {{32{w_raw[31]}}, w_raw[31:0]};
         3'b011:  w_load_ext = w_raw;
         3'b100:  w_load_ext = {56'd0, w_raw[7:0]};
         3'b101:  w_load_ext = {48'd0, w_raw[15:0]};
         3'b110:  w_load_ext = {32'd0, w_raw[31:0]};
         default: w_load_ext = '0;
      endcase
   end

   // Latency FSM: IDLE -> WAIT for N-1 counted cycles, then back to IDLE.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_valid && (MEM_LATENCY > 0)) begin
                  r_state <= S_WAIT;
                  r_cnt   <= CNT_INIT;
               end
            end
            S_WAIT: begin
               if (r_cnt != 4'd0) r_cnt   <= r_cnt - 4'd1;
               else               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Store commit: only the size-selected low bytes of rs2 are written.
   always_ff @(posedge clk) begin
      // NOTE: the memory array is deliberately not reset; contents survive
      // reset and a reset-free array maps onto plain RAM.
      if (!rst && w_complete && ex_mem_Memwrite) begin
         for (int i = 0; i < 8; i++) begin
            if (i < int'(w_nbytes)) r_mem[AW'(w_addr + AW'(i))] <= w_st_data[8*i +: 8];
         end
      end
   end

   // MEM/WB register: bubble while stalled, otherwise pass-through,
   // exception, or completed memory access.
   always_ff @(posedge clk) begin
      if (rst || mem_stall) begin
         mem_wb_rd         <= '0;
         mem_wb_MemtoReg   <= 1'b0;
         mem_wb_RegWrite   <= 1'b0;
         mem_wb_alu_result <= '0;
         mem_wb_mem_data   <= '0;
         mem_wb_exc        <= 1'b0;
      end else if (w_illegal) begin
         mem_wb_rd         <= ex_mem_rd;
         mem_wb_MemtoReg   <= ex_mem_MemtoReg;
         mem_wb_RegWrite   <= 1'b0;
         mem_wb_alu_result <= ex_mem_alu_result;
         mem_wb_mem_data   <= '0;
         mem_wb_exc        <= 1'b1;
      end else begin
         mem_wb_rd         <= ex_mem_rd;
         mem_wb_MemtoReg   <= ex_mem_MemtoReg;
         mem_wb_RegWrite   <= ex_mem_Regwrite;
         mem_wb_alu_result <= ex_mem_alu_result;
         mem_wb_mem_data   <= (w_complete && ex_mem_Memread) ? w_load_ext[XLEN-1:0] : '0;
         mem_wb_exc        <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_stage_param.sv
// tb_mem_stage_param: directed self-checking bench for mem_stage_param.
// Two instances share one input bus: u0 with single-cycle memory and u3
// with three extra wait cycles. Inputs change on the falling edge and
// outputs are sampled there, away from the active rising edge.
module tb_mem_stage_param;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rd;
   logic        mw, mr, m2r, rw;
   logic [2:0]  f3;
   logic [63:0] alu, rs2;

   logic        s0, s3;
   logic [4:0]  rd0, rd3;
   logic        m2r0, m2r3, rw0, rw3, exc0, exc3;
   logic [63:0] alu0, alu3, dat0, dat3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage_param #(.XLEN(64), .DEPTH_BYTES(1024), .MEM_LATENCY(0)) u0 (
      .clk(clk), .rst(rst), .ex_mem_rd(rd), .ex_mem_Memwrite(mw),
      .ex_mem_Memread(mr), .ex_mem_MemtoReg(m2r), .ex_mem_Regwrite(rw),
      .ex_mem_funct3(f3), .ex_mem_alu_result(alu), .ex_mem_rs2(rs2),
      .mem_stall(s0), .mem_wb_rd(rd0), .mem_wb_MemtoReg(m2r0),
      .mem_wb_RegWrite(rw0), .mem_wb_alu_result(alu0),
      .mem_wb_mem_data(dat0), .mem_wb_exc(exc0));

   mem_stage_param #(.XLEN(64), .DEPTH_BYTES(1024), .MEM_LATENCY(3)) u3 (
      .clk(clk), .rst(rst), .ex_mem_rd(rd), .ex_mem_Memwrite(mw),
      .ex_mem_Memread(mr), .ex_mem_MemtoReg(m2r), .ex_mem_Regwrite(rw),
      .ex_mem_funct3(f3), .ex_mem_alu_result(alu), .ex_mem_rs2(rs2),
      .mem_stall(s3), .mem_wb_rd(rd3), .mem_wb_MemtoReg(m2r3),
      .mem_wb_RegWrite(rw3), .mem_wb_alu_result(alu3),
      .mem_wb_mem_data(dat3), .mem_wb_exc(exc3));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_op(input logic [4:0] i_rd, input logic i_w, input logic i_r,
                         input logic i_m2r, input logic i_rw, input logic [2:0] i_f3,
                         input logic [63:0] i_alu, input logic [63:0] i_rs2);
      rd = i_rd; mw = i_w; mr = i_r; m2r = i_m2r; rw = i_rw;
      f3 = i_f3; alu = i_alu; rs2 = i_rs2;
   endtask

   task automatic set_idle();
      set_op(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0);
   endtask

   // Single-cycle access on u0: never stalls, result after one edge.
   task automatic run0(input string tag);
      #1 check({tag, "_stall0"}, 64'(s0), 64'd0);
      step();
   endtask

   // Three-wait access on u3: stall for three cycles with bubbles in
   // MEM/WB, then stall drops and the result lands on the following edge.
   task automatic run3(input string tag);
      for (int k = 0; k < 3; k++) begin
         #1 check({tag, "_stall3"}, 64'(s3), 64'd1);
         step();
         check({tag, "_bubble_rw"},   64'(rw3),  64'd0);
         check({tag, "_bubble_rd"},   64'(rd3),  64'd0);
         check({tag, "_bubble_data"}, dat3,      64'd0);
      end
      #1 check({tag, "_stall3_end"}, 64'(s3), 64'd0);
      step();
   endtask

   initial begin
      rst = 1'b1;
      set_idle();
      step();
      step();
      check("rst_rd0",   64'(rd0),  64'd0);
      check("rst_rw0",   64'(rw0),  64'd0);
      check("rst_m2r0",  64'(m2r0), 64'd0);
      check("rst_alu0",  alu0,      64'd0);
      check("rst_data0", dat0,      64'd0);
      check("rst_exc0",  64'(exc0), 64'd0);
      check("rst_data3", dat3,      64'd0);
      rst = 1'b0;
      #1 check("post_rst_stall0", 64'(s0), 64'd0);
      check("post_rst_stall3", 64'(s3), 64'd0);
      @(negedge clk);

      // ---------------- single-cycle instance ----------------
      set_op(5'd0, 1, 0, 0, 0, 3'b011, 64'd16, 64'h1122334455667788);
      run0("sd16");
      check("sd16_exc", 64'(exc0), 64'd0);

      set_op(5'd5, 0, 1, 1, 1, 3'b011, 64'd16, 64'd0);
      run0("ld16");
      check("ld16_data", dat0, 64'h1122334455667788);
      check("ld16_rd",   64'(rd0), 64'd5);
      check("ld16_rw",   64'(rw0), 64'd1);
      check("ld16_m2r",  64'(m2r0), 64'd1);
      check("ld16_exc",  64'(exc0), 64'd0);

      set_op(5'd5, 0, 1, 1, 1, 3'b000, 64'd16, 64'd0);
      run0("lb16");
      check("lb16_data", dat0, 64'hFFFFFFFFFFFFFF88);

      set_op(5'd5, 0, 1, 1, 1, 3'b100, 64'd16, 64'd0);
      run0("lbu16");
      check("lbu16_data", dat0, 64'h88);

      set_op(5'd5, 0, 1, 1, 1, 3'b001, 64'd16, 64'd0);
      run0("lh16");
      check("lh16_data", dat0, 64'h7788);

      set_op(5'd5, 0, 1, 1, 1, 3'b110, 64'd20, 64'd0);
      run0("lwu20");
      check("lwu20_data", dat0, 64'h11223344);

      set_op(5'd5, 0, 1, 1, 1, 3'b010, 64'd16, 64'd0);
      run0("lw16");
      check("lw16_data", dat0, 64'h55667788);

      // Misaligned load: exception, write-back suppressed, rd/alu pass through.
      set_op(5'd9, 0, 1, 1, 1, 3'b010, 64'd18, 64'd0);
      run0("lw18");
      check("lw18_exc",  64'(exc0), 64'd1);
      check("lw18_rw",   64'(rw0),  64'd0);
      check("lw18_data", dat0,      64'd0);
      check("lw18_rd",   64'(rd0),  64'd9);
      check("lw18_alu",  alu0,      64'd18);

      // Misaligned store must leave memory untouched.
      set_op(5'd0, 1, 0, 0, 0, 3'b011, 64'd17, 64'd0);
      run0("sd17");
      check("sd17_exc", 64'(exc0), 64'd1);

      // Read and write together, and funct3 111, are both illegal.
      set_op(5'd4, 1, 1, 0, 1, 3'b000, 64'd16, 64'd0);
      run0("rdwr");
      check("rdwr_exc", 64'(exc0), 64'd1);
      set_op(5'd4, 0, 1, 0, 1, 3'b111, 64'd16, 64'd0);
      run0("f3_111");
      check("f3_111_exc", 64'(exc0), 64'd1);

      set_op(5'd5, 0, 1, 1, 1, 3'b011, 64'd16, 64'd0);
      run0("ld16_again");
      check("ld16_again_data", dat0, 64'h1122334455667788);

      // Byte store updates one byte only; load the very next cycle sees it.
      set_op(5'd0, 1, 0, 0, 0, 3'b000, 64'd17, 64'h99);
      run0("sb17");
      set_op(5'd5, 0, 1, 1, 1, 3'b011, 64'd16, 64'd0);
      run0("ld16_raw");
      check("ld16_raw_data", dat0, 64'h1122334455669988);

      // Address wrap: 1029 aliases byte 5; only the low byte of rs2 lands.
      set_op(5'd0, 1, 0, 0, 0, 3'b000, 64'd1029, 64'hFFFFFFFFFFFFFFAB);
      run0("sb1029");
      set_op(5'd5, 0, 1, 1, 1, 3'b100, 64'd5, 64'd0);
      run0("lbu5");
      check("lbu5_data", dat0, 64'hAB);
      set_op(5'd5, 0, 1, 1, 1, 3'b000, 64'd5, 64'd0);
      run0("lb5");
      check("lb5_data", dat0, 64'hFFFFFFFFFFFFFFAB);

      // Non-memory ALU pass-through.
      set_op(5'd7, 0, 0, 0, 1, 3'b011, 64'd42, 64'd0);
      run0("alu");
      check("alu_rd",   64'(rd0),  64'd7);
      check("alu_res",  alu0,      64'd42);
      check("alu_rw",   64'(rw0),  64'd1);
      check("alu_data", dat0,      64'd0);
      check("alu_exc",  64'(exc0), 64'd0);

      // ---------------- three-wait instance ----------------
      rst = 1'b1;
      set_idle();
      step();
      rst = 1'b0;

      set_op(5'd0, 1, 0, 0, 0, 3'b011, 64'd8, 64'h000000000000BEEF);
      run3("sd8");
      check("sd8_exc", 64'(exc3), 64'd0);

      set_op(5'd3, 0, 1, 1, 1, 3'b010, 64'd8, 64'd0);
      run3("lw8");
      check("lw8_data", dat3, 64'h000000000000BEEF);
      check("lw8_rd",   64'(rd3), 64'd3);
      check("lw8_rw",   64'(rw3), 64'd1);

      // Back-to-back ALU op after the access: no stall, immediate pass-through.
      set_op(5'd7, 0, 0, 0, 1, 3'b000, 64'd42, 64'd0);
      #1 check("alu3_stall", 64'(s3), 64'd0);
      step();
      check("alu3_rd", 64'(rd3), 64'd7);

      // Reset during WAIT abandons the store.
      set_op(5'd0, 1, 0, 0, 0, 3'b011, 64'd8, 64'h000000000000DEAD);
      #1 check("sd_abort_stall", 64'(s3), 64'd1);
      step();
      rst = 1'b1;
      set_idle();
      step();
      check("abort_rd",   64'(rd3),  64'd0);
      check("abort_rw",   64'(rw3),  64'd0);
      check("abort_data", dat3,      64'd0);
      check("abort_exc",  64'(exc3), 64'd0);
      rst = 1'b0;
      #1 check("abort_stall", 64'(s3), 64'd0);
      @(negedge clk);

      set_op(5'd3, 0, 1, 1, 1, 3'b011, 64'd8, 64'd0);
      run3("ld8");
      check("ld8_data", dat3, 64'h000000000000BEEF);

      set_idle();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_param.md
Name: mem_stage_param

Overview:
- Parametrised successor to the single-cycle MEM stage.
- Sits between the EX/MEM and MEM/WB pipeline registers. Contains a byte-addressed, little-endian data memory and the MEM/WB register.
- New capabilities:
  - RV64/RV32 width selection.
  - Sized loads and stores (byte, half, word, double), with sign or zero extension on loads.
  - Configurable multi-cycle memory latency, with a stall handshake to upstream stages.
  - Misaligned and illegal access detection, carried to WB as an exception flag.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- DEPTH_BYTES, 1024, data memory size in bytes; must be a power of two.
- MEM_LATENCY, 0, extra wait cycles per memory access; 0 means single-cycle; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_mem_rd  in  5  destination register.
- ex_mem_Memwrite  in  1  store request.
- ex_mem_Memread  in  1  load request.
- ex_mem_MemtoReg  in  1  WB select: memory data vs ALU result.
- ex_mem_Regwrite  in  1  register write enable.
- ex_mem_funct3  in  3  access size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 011 ld/sd, 100 lbu, 101 lhu, 110 lwu.
- ex_mem_alu_result  in  XLEN  effective address, or ALU result passed through.
- ex_mem_rs2  in  XLEN  store data; the low bytes are used.
- mem_stall  out  1  combinational; upstream holds its EX/MEM values and freezes while high.
- mem_wb_rd  out  5  registered.
- mem_wb_MemtoReg  out  1  registered.
- mem_wb_RegWrite  out  1  registered.
- mem_wb_alu_result  out  XLEN  registered.
- mem_wb_mem_data  out  XLEN  registered; extended load data.
- mem_wb_exc  out  1  registered; misaligned or illegal access flag.

Behaviour:
- Reset:
  - All mem_wb_* outputs go to 0.
  - FSM goes to IDLE and the wait counter clears.
  - mem_stall is 0 in the cycle after reset.
  - Memory contents are unaffected by reset.
- Address:
  - Byte address = ex_mem_alu_result[log2(DEPTH_BYTES)-1:0].
  - Upper bits are ignored, so addresses wrap modulo DEPTH_BYTES.
- Access is "valid" when exactly one of Memread/Memwrite is 1 and the access is legal.
- Illegal access cases:
  - Memread and Memwrite both 1.
  - Address not aligned to the access size (half: a[0]; word: a[1:0]; double: a[2:0]).
  - funct3 = 111.
  - funct3 = 011 or 110 when XLEN = 32.
- Illegal access handling:
  - No memory access and no stall.
  - At the next edge, MEM/WB loads mem_wb_exc = 1, mem_wb_RegWrite = 0, mem_wb_mem_data = 0.
  - rd and alu_result pass through unchanged.
- Non-memory operation (Memread = Memwrite = 0):
  - MEM/WB loads all ex_mem_* fields at the next edge.
  - mem_wb_mem_data = 0, mem_wb_exc = 0, no stall.
- FSM states: IDLE and WAIT.
  - IDLE, valid access, MEM_LATENCY = 0:
    - Store commits and load data registers at the next edge.
    - Stay in IDLE; mem_stall = 0.
  - IDLE, valid access, MEM_LATENCY = N > 0:
    - mem_stall = 1 immediately (combinational).
    - Next edge: go to WAIT, counter = N-1, MEM/WB loads a bubble.
  - WAIT with counter > 0:
    - mem_stall = 1, counter decrements, MEM/WB loads a bubble each edge.
  - WAIT with counter = 0:
    - mem_stall = 0.
    - Next edge: store commits exactly once, load result registers to MEM/WB, FSM returns to IDLE.
- Bubble definition: RegWrite = 0, MemtoReg = 0, rd = 0, exc = 0, data = 0.
- Timing summary: access presented in cycle t leaves mem_stall high in cycles t..t+N-1, and the result appears at the edge ending cycle t+N.
- Store: writes only the size-selected low bytes of rs2, little-endian; other bytes are unchanged.
- Load:
  - Sign-extends for 000/001/010.
  - Zero-extends for 100/101/110.
  - For XLEN = 32, lw fills all 32 bits.
- Read-after-write: a load in the cycle immediately after a committed store to the same bytes returns the new data.
- Inputs are sampled only at completion. Changing inputs while mem_stall = 1 is an upstream protocol violation; behaviour is undefined.
- rst asserted while in WAIT:
  - Access is abandoned and no store commits.
  - FSM goes to IDLE; outputs follow the reset values.

Test Plan:
- Reset, then MEM_LATENCY = 0: sd rs2 = 0x1122334455667788 at address 16, then ld at 16 → mem_wb_mem_data = 0x1122334455667788, mem_wb_exc = 0, mem_stall never asserted.
- Sized loads, with address 16 holding 0x...88 at byte 16: lb @16 → 0xFFFFFFFFFFFFFF88; lbu @16 → 0x88; lh @16 → 0x7788; lwu @20 → 0x11223344.
- Misaligned: lw at address 18 with Regwrite = 1 → next edge mem_wb_exc = 1, mem_wb_RegWrite = 0, no stall; memory unchanged (a following ld @16 still returns the prior value).
- MEM_LATENCY = 3: lw presented at cycle 0 → mem_stall high in cycles 0–2, bubbles in MEM/WB, data valid after the edge ending cycle 3; a store under the same sequence commits exactly once.
- Wrap and pass-through, DEPTH_BYTES = 1024: sb 0xAB at address 1024+5, then lbu at 5 → 0xAB. ALU op with rd = 7, result 42 → next edge mem_wb_rd = 7, mem_wb_alu_result = 42, mem_wb_RegWrite = 1.
- Reset mid-WAIT with MEM_LATENCY = 3: sd 0xDEAD to address 8, assert rst in cycle 1 → outputs 0 and FSM IDLE; a following ld @8 returns the old value (no commit).
